// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the execute-side operand stage.
//   XLEN_DEFAULT  : default datapath width
//   RA_W_DEFAULT  : default register-address width
//   alu_cont_t    : 3-bit ALU control code and its named values
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;
    localparam int ALU_CONT_W   = 3;

    typedef enum logic [ALU_CONT_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_cont_t;

endpackage : riscv_pkg

// File: rtl/ex_fwd_mux.sv
// ----------------------------------------------------------------------------
// ex_fwd_mux
// Selects the freshest value of one source register for the execute stage.
// MEM result wins over WB result; register x0 is never forwarded; with i_en
// low the stored register data always passes through.
// Ports:
//   i_en                                  forwarding enable
//   i_src                                 source register address
//   i_stored                              register data held in the entry
//   i_mem_rd / i_mem_reg_write / i_mem_result   MEM-stage producer
//   i_wb_rd  / i_wb_reg_write  / i_wb_result    WB-stage producer
//   o_data                                forwarded operand
// ----------------------------------------------------------------------------
module ex_fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            i_en,
    input  logic [RA_W-1:0] i_src,
    input  logic [XLEN-1:0] i_stored,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic            i_mem_reg_write,
    input  logic [XLEN-1:0] i_mem_result,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_wb_reg_write,
    input  logic [XLEN-1:0] i_wb_result,
    output logic [XLEN-1:0] o_data
);

    logic w_src_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nz  = |i_src;
    assign w_mem_hit = i_en & w_src_nz & i_mem_reg_write & (i_mem_rd == i_src);
    assign w_wb_hit  = i_en & w_src_nz & i_wb_reg_write  & (i_wb_rd  == i_src);

    always_comb begin
        o_data = i_stored;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_data = i_wb_result;
        end
    end

endmodule : ex_fwd_mux

// File: rtl/ex_operand_stage.sv
// ----------------------------------------------------------------------------
// ex_operand_stage
// Single-entry pipeline register between decode and the ALU. Captures the
// decoded instruction and its register data, presents ALU operands, and
// resolves read-after-write dependencies either by forwarding from MEM/WB or
// by stalling decode.
//
// Build option: define RISCV_FORWARD_EN to enable MEM/WB forwarding (with
// operand refresh while the entry is stalled); hazard_stall is then tied 0.
// Without it, operands are the captured register data and decode is stalled
// while any in-flight writer targets a used source register.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid / id_ready             decode-side handshake
//   id_rs1, id_rs2, id_rd           register addresses
//   id_rs1_data, id_rs2_data, id_imm  register data and immediate
//   id_alu_src, id_alu_cont, id_reg_write  operand-B select, ALU code, writes rd
//   flush                           kill the held / incoming entry
//   mem_*, wb_*                     forwarding sources
//   ex_valid / ex_ready             handshake toward the ALU
//   ex_a, ex_b, ex_alu_cont         ALU operands and control
//   ex_rd, ex_reg_write             destination info
//   hazard_stall                    RAW stall indicator
// ----------------------------------------------------------------------------
module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [2:0]      id_alu_cont,
    input  logic            id_reg_write,

    input  logic            flush,

    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [2:0]      ex_alu_cont,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,

    output logic            hazard_stall
);

`ifdef RISCV_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Held entry
    // ------------------------------------------------------------------
    logic            r_valid;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_alu_src;
    alu_cont_t       r_alu_cont;
    logic            r_reg_write;

    logic            w_transfer;
    logic            w_hazard;

    // ------------------------------------------------------------------
    // Forwarding muxes: index 0 serves rs1, index 1 serves rs2. Both work
    // only from the held entry and the MEM/WB inputs, so there is no
    // combinational route from decode to the ex_* outputs.
    // ------------------------------------------------------------------
    logic [RA_W-1:0] w_src    [2];
    logic [XLEN-1:0] w_stored [2];
    logic [XLEN-1:0] w_fwd    [2];

    assign w_src[0]    = r_rs1;
    assign w_src[1]    = r_rs2;
    assign w_stored[0] = r_rs1_data;
    assign w_stored[1] = r_rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            ex_fwd_mux #(
                .XLEN (XLEN),
                .RA_W (RA_W)
            ) u_fwd_mux (
                .i_en            (FWD_EN),
                .i_src           (w_src[gi]),
                .i_stored        (w_stored[gi]),
                .i_mem_rd        (mem_rd),
                .i_mem_reg_write (mem_reg_write),
                .i_mem_result    (mem_result),
                .i_wb_rd         (wb_rd),
                .i_wb_reg_write  (wb_reg_write),
                .i_wb_result     (wb_result),
                .o_data          (w_fwd[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
`ifdef RISCV_FORWARD_EN
    assign w_hazard = 1'b0;
`else
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A source matches when any in-flight writer (held entry, MEM, WB)
    // targets it; x0 never creates a dependency.
    always_comb begin
        w_rs1_hit = (|id_rs1) &
                    ((r_valid & r_reg_write & (r_rd == id_rs1)) |
                     (mem_reg_write & (mem_rd == id_rs1)) |
                     (wb_reg_write  & (wb_rd  == id_rs1)));
        w_rs2_hit = (|id_rs2) &
                    ((r_valid & r_reg_write & (r_rd == id_rs2)) |
                     (mem_reg_write & (mem_rd == id_rs2)) |
                     (wb_reg_write  & (wb_rd  == id_rs2)));
    end

    // rs2 is irrelevant when the immediate supplies operand B.
    assign w_hazard = id_valid & (w_rs1_hit | (~id_alu_src & w_rs2_hit));
`endif

    assign hazard_stall = w_hazard;
    assign id_ready     = (~r_valid | ex_ready) & ~w_hazard;
    assign w_transfer   = id_valid & id_ready;

    // ------------------------------------------------------------------
    // Entry update. Priority: flush, new transfer (also covers retire +
    // transfer in one cycle), plain retire, stalled refresh.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_cont  <= ALU_ADD;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            // Dropping the incoming instruction too; its fields are left alone.
            r_valid <= 1'b0;
        end else if (w_transfer) begin
            r_valid     <= 1'b1;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_alu_cont  <= alu_cont_t'(id_alu_cont);
            r_reg_write <= id_reg_write;
        end else if (r_valid & ex_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // Stalled: absorb any forwarded value now, since its producer
            // may leave WB before the ALU accepts this entry. Without
            // forwarding the muxes return the stored data unchanged.
            r_rs1_data <= w_fwd[0];
            r_rs2_data <= w_fwd[1];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_valid     = r_valid;
    assign ex_a         = w_fwd[0];
    assign ex_b         = r_alu_src ? r_imm : w_fwd[1];
    assign ex_alu_cont  = r_alu_cont;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write;

endmodule : ex_operand_stage

// File: tb/tb_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_operand_stage
// Directed tests for ex_operand_stage with hand-computed expectations.
// Forwarding tests run when RISCV_FORWARD_EN is defined, stall tests otherwise.
// ----------------------------------------------------------------------------
module tb_ex_operand_stage;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic            id_alu_src;
    logic [2:0]      id_alu_cont;
    logic            id_reg_write;
    logic            flush;
    logic [RA_W-1:0] mem_rd, wb_rd;
    logic            mem_reg_write, wb_reg_write;
    logic [XLEN-1:0] mem_result, wb_result;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_a, ex_b;
    logic [2:0]      ex_alu_cont;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            hazard_stall;

    int n_checks = 0;
    int n_fail   = 0;

    ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_alu_src    (id_alu_src),
        .id_alu_cont   (id_alu_cont),
        .id_reg_write  (id_reg_write),
        .flush         (flush),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_alu_cont   (ex_alu_cont),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .hazard_stall  (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                          input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d1,
                          input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                          input logic src, input logic [2:0] cont, input logic rw);
        id_valid     = 1'b1;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_rs1_data  = d1;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_alu_src   = src;
        id_alu_cont  = cont;
        id_reg_write = rw;
    endtask

    task automatic clr_fwd();
        mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
        wb_rd  = '0; wb_reg_write  = 1'b0; wb_result  = '0;
    endtask

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alu_src = 1'b0; id_alu_cont = '0; id_reg_write = 1'b0;
        clr_fwd();

        // ---------------- reset state ----------------
        $display("txn reset");
        repeat (2) tick();
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_a", ex_a, 0);
        check("rst_ex_b", ex_b, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_id_ready", id_ready, 1);
        check("rst_hazard", hazard_stall, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- plain op ----------------
        $display("txn plain op 5,7 ADD");
        set_id(1, 2, 3, 5, 7, 0, 1'b0, ALU_ADD, 1'b0);
        #1 check("plain_id_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        #1;
        check("plain_ex_valid", ex_valid, 1);
        check("plain_ex_a", ex_a, 5);
        check("plain_ex_b", ex_b, 7);
        check("plain_alu_cont", ex_alu_cont, 3'b000);
        tick();
        check("plain_retire", ex_valid, 0);

        // ---------------- immediate operand ----------------
        $display("txn immediate OR");
        set_id(1, 2, 0, 32'h100, 32'h200, 32'h10, 1'b1, ALU_OR, 1'b0);
        tick();
        id_valid = 1'b0;
        #1;
        check("imm_ex_a", ex_a, 32'h100);
        check("imm_ex_b", ex_b, 32'h10);
        check("imm_alu_cont", ex_alu_cont, 3'b011);
        tick();

        // ---------------- back-to-back ----------------
        $display("txn back-to-back");
        set_id(1, 2, 0, 32'hA1, 32'hA2, 0, 1'b0, ALU_SUB, 1'b0);
        tick();
        set_id(1, 2, 0, 32'hB1, 32'hB2, 0, 1'b0, ALU_AND, 1'b0);
        #1;
        check("b2b_first_valid", ex_valid, 1);
        check("b2b_first_a", ex_a, 32'hA1);
        check("b2b_id_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        #1;
        check("b2b_second_valid", ex_valid, 1);
        check("b2b_second_a", ex_a, 32'hB1);
        check("b2b_second_cont", ex_alu_cont, 3'b010);
        tick();
        check("b2b_drain", ex_valid, 0);

        // ---------------- flush with transfer ----------------
        $display("txn flush with transfer");
        set_id(1, 2, 0, 32'hC1, 32'hC2, 0, 1'b0, ALU_ADD, 1'b0);
        flush = 1'b1;
        #1 check("flush_id_ready", id_ready, 1);
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        #1 check("flush_ex_valid", ex_valid, 0);

        // ---------------- hold under stall ----------------
        $display("txn hold under stall");
        ex_ready = 1'b0;
        set_id(7, 8, 5, 32'hD1, 32'hD2, 0, 1'b0, ALU_SUB, 1'b1);
        tick();
        set_id(9, 10, 11, 32'hE1, 32'hE2, 0, 1'b0, ALU_ADD, 1'b0);
        #1 check("hold_id_ready", id_ready, 0);
        tick();
        id_valid = 1'b0;
        #1;
        check("hold_ex_valid", ex_valid, 1);
        check("hold_ex_a", ex_a, 32'hD1);
        check("hold_ex_b", ex_b, 32'hD2);
        check("hold_ex_rd", ex_rd, 5);
        check("hold_reg_write", ex_reg_write, 1);

        // ---------------- asynchronous reset mid-stall ----------------
        $display("txn reset mid-stall");
        #2 rst_n = 1'b0;
        #1;
        check("arst_ex_valid", ex_valid, 0);
        check("arst_ex_a", ex_a, 0);
        check("arst_ex_b", ex_b, 0);
        check("arst_ex_rd", ex_rd, 0);
        check("arst_reg_write", ex_reg_write, 0);
        check("arst_alu_cont", ex_alu_cont, 0);
        #1 rst_n = 1'b1;
        #1 check("arst_id_ready", id_ready, 1);
        ex_ready = 1'b1;
        tick();

`ifdef RISCV_FORWARD_EN
        // ---------------- forward priority ----------------
        $display("txn forward priority");
        ex_ready = 1'b0;
        set_id(3, 0, 0, 32'h11, 32'h55, 0, 1'b0, ALU_ADD, 1'b0);
        tick();
        set_id(3, 3, 0, 0, 0, 0, 1'b0, ALU_ADD, 1'b0);
        mem_rd = 3; mem_reg_write = 1'b1; mem_result = 32'hAA;
        wb_rd  = 3; wb_reg_write  = 1'b1; wb_result  = 32'hBB;
        #1;
        check("fwd_mem_prio", ex_a, 32'hAA);
        check("fwd_no_stall", hazard_stall, 0);
        id_valid = 1'b0;
        mem_reg_write = 1'b0;
        #1 check("fwd_wb", ex_a, 32'hBB);
        wb_reg_write = 1'b0;
        #1 check("fwd_none", ex_a, 32'h11);
        ex_ready = 1'b1;
        tick();

        $display("txn forward x0");
        ex_ready = 1'b0;
        set_id(0, 0, 0, 32'h22, 0, 0, 1'b0, ALU_ADD, 1'b0);
        tick();
        id_valid = 1'b0;
        mem_rd = 0; mem_reg_write = 1'b1; mem_result = 32'hAA;
        wb_rd  = 0; wb_reg_write  = 1'b1; wb_result  = 32'hBB;
        #1 check("fwd_x0", ex_a, 32'h22);
        clr_fwd();
        ex_ready = 1'b1;
        tick();

        // ---------------- stall refresh ----------------
        $display("txn stall refresh");
        ex_ready = 1'b0;
        set_id(0, 4, 0, 0, 32'h99, 0, 1'b0, ALU_ADD, 1'b0);
        tick();
        id_valid = 1'b0;
        #1 check("refresh_before", ex_b, 32'h99);
        tick();
        wb_rd = 4; wb_reg_write = 1'b1; wb_result = 32'h1234;
        #1 check("refresh_live", ex_b, 32'h1234);
        tick();
        clr_fwd();
        #1 check("refresh_kept", ex_b, 32'h1234);
        tick();
        ex_ready = 1'b1;
        #1;
        check("refresh_ready_b", ex_b, 32'h1234);
        check("refresh_ready_valid", ex_valid, 1);
        tick();
        check("refresh_retire", ex_valid, 0);
`else
        // ---------------- captured data, no forwarding ----------------
        $display("txn no forwarding");
        ex_ready = 1'b0;
        set_id(3, 0, 0, 32'h11, 0, 0, 1'b0, ALU_ADD, 1'b0);
        tick();
        id_valid = 1'b0;
        mem_rd = 3; mem_reg_write = 1'b1; mem_result = 32'hAA;
        #1 check("nofwd_ex_a", ex_a, 32'h11);
        clr_fwd();
        ex_ready = 1'b1;
        tick();

        // ---------------- RAW stall until producer leaves WB ----------------
        $display("txn RAW stall rd=6");
        ex_ready = 1'b0;
        set_id(1, 2, 6, 32'h61, 32'h62, 0, 1'b0, ALU_ADD, 1'b1);
        tick();
        set_id(6, 0, 7, 32'h71, 0, 0, 1'b0, ALU_ADD, 1'b0);
        #1;
        check("raw_entry_stall", hazard_stall, 1);
        check("raw_entry_ready", id_ready, 0);
        ex_ready = 1'b1;
        tick();
        mem_rd = 6; mem_reg_write = 1'b1; mem_result = 32'h66;
        #1;
        check("raw_retired", ex_valid, 0);
        check("raw_mem_stall", hazard_stall, 1);
        check("raw_mem_ready", id_ready, 0);
        tick();
        mem_reg_write = 1'b0;
        wb_rd = 6; wb_reg_write = 1'b1; wb_result = 32'h66;
        #1 check("raw_wb_stall", hazard_stall, 1);
        tick();
        clr_fwd();
        #1;
        check("raw_clear_stall", hazard_stall, 0);
        check("raw_clear_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        #1;
        check("raw_issue_valid", ex_valid, 1);
        check("raw_issue_a", ex_a, 32'h71);
        tick();

        // ---------------- rs2 usage and x0 ----------------
        $display("txn rs2 usage and x0");
        wb_rd = 9; wb_reg_write = 1'b1; wb_result = 32'h9;
        set_id(0, 9, 0, 0, 0, 32'h4, 1'b1, ALU_ADD, 1'b0);
        #1 check("rs2_imm_no_stall", hazard_stall, 0);
        id_alu_src = 1'b0;
        #1 check("rs2_used_stall", hazard_stall, 1);
        wb_rd = 0;
        id_rs1 = 0; id_rs2 = 0;
        #1 check("x0_no_stall", hazard_stall, 0);
        id_valid = 1'b0;
        clr_fwd();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_operand_stage

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RA_W, default 5, register-address width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid / id_ready  in / out  1 / 1  decode-side handshake.
REQ-006 id_rs1, id_rs2, id_rd  in  RA_W each  source and destination register addresses.
REQ-007 id_rs1_data, id_rs2_data, id_imm  in  XLEN each  register-file read data and immediate.
REQ-008 id_alu_src  in  1  1 selects id_imm as operand B.
REQ-009 id_alu_cont  in  3  ALU control code.
REQ-010 id_reg_write  in  1  instruction writes id_rd.
REQ-011 flush  in  1  synchronous kill of the held entry.
REQ-012 mem_rd / mem_reg_write / mem_result  in  RA_W / 1 / XLEN  MEM-stage forwarding source.
REQ-013 wb_rd / wb_reg_write / wb_result  in  RA_W / 1 / XLEN  WB-stage forwarding source.
REQ-014 ex_valid / ex_ready  out / in  1 / 1  handshake toward the ALU.
REQ-015 ex_a, ex_b  out  XLEN each  ALU operands A and B.
REQ-016 ex_alu_cont  out  3  ALU control code.
REQ-017 ex_rd / ex_reg_write  out  RA_W / 1  destination info passed downstream.
REQ-018 hazard_stall  out  1  RAW hazard stall indicator.

Function
REQ-019 SHALL hold a single-entry register (valid bit, rs1, rs2, rd, operands, alu_src, alu_cont, reg_write).
REQ-020 id_ready = (!ex_valid | ex_ready) & !hazard_stall.
- Transfer happens when id_valid & id_ready.
- Transfer loads the entry; ex_valid is 1 on the next cycle.
REQ-021 ex_valid & ex_ready with no new transfer SHALL clear ex_valid on the next cycle.
- Simultaneous retire and transfer SHALL load the new entry back-to-back, with no bubble.
REQ-022 Latency SHALL be 1 cycle from id transfer to ex_valid.
- Entry SHALL be held unchanged while ex_valid & !ex_ready, except the operand refresh in REQ-025.
REQ-023 flush SHALL clear ex_valid on the next edge.
- flush overrides a simultaneous transfer; that instruction is dropped.
- id_ready is unaffected by flush.
REQ-024 Forward select (FORWARD_EN defined), per source s in {rs1, rs2}:
- if mem_reg_write & mem_rd==s & s!=0 -> mem_result (MEM has priority);
- else if wb_reg_write & wb_rd==s & s!=0 -> wb_result;
- else the stored register data.
REQ-025 While ex_valid & !ex_ready, each forwarded value SHALL be written back into the stored operand every cycle, so a producer retiring during a stall is not lost.
REQ-026 ex_a = forwarded rs1; ex_b = id_imm when alu_src, else forwarded rs2.
- Register x0 is never forwarded.
REQ-027 All ex_* outputs SHALL be registered or derived combinationally only from the entry and the mem/wb inputs.
- No combinational path from id_* to ex_*.

Reset
REQ-028 rst_n low SHALL asynchronously clear ex_valid, ex_a, ex_b, ex_alu_cont, ex_rd, ex_reg_write and the stored entry to 0.
- The stored operand values reset to 0.
REQ-029 Reset mid-stall SHALL discard the held entry; after release, id_ready = 1 (when hazard_stall = 0).

Configuration
REQ-030 Macro RISCV_FORWARD_EN defined: forwarding per REQ-024/025; hazard_stall tied 0.
REQ-031 RISCV_FORWARD_EN undefined: no forwarding; operands are the captured register data.
- hazard_stall = id_valid & (id_rs1 or id_rs2, nonzero, used) matches a writing rd in the entry (ex_valid), the MEM stage, or the WB stage.
- id_rs2 counts as used only when !id_alu_src.

Structure
REQ-032 Package riscv_pkg SHALL hold:
- XLEN and RA_W defaults;
- the 3-bit ALU control type;
- the codes ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011.
REQ-033 One sub-module ex_fwd_mux (source address, stored data, mem/wb inputs -> forwarded data) SHALL be instantiated twice.

Verification
REQ-034 Plain op: rs1_data=5, rs2_data=7, alu_cont=000, no forwarding matches -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_alu_cont=000.
REQ-035 Forward priority: rs1=3, mem_rd=3 and wb_rd=3 both writing, mem_result=0xAA, wb_result=0xBB -> ex_a=0xAA.
- Same case with rs1=0 -> ex_a = stored data.
REQ-036 Stall refresh: entry rs2=4 held with ex_ready=0 for 3 cycles; wb_rd=4 writes 0x1234 in cycle 2, then goes idle -> ex_b=0x1234 when ex_ready rises.
REQ-037 Back-to-back and flush:
- two id transfers with ex_ready=1 -> ex_valid stays 1 for 2 cycles, no bubble;
- flush asserted together with a transfer -> ex_valid=0 next cycle.
REQ-038 Reset: rst_n pulsed low mid-stall (asynchronously) -> all ex_* outputs 0 immediately; id_ready=1 after release.
REQ-039 RISCV_FORWARD_EN undefined: id_rs1=6 while the entry has rd=6 with reg_write -> hazard_stall=1, id_ready=0 until the rd=6 producer leaves WB.
